median: RTL and testbench

- Streaming 9-sample median filter for 8-bit unsigned pixels.
- Takes a burst of nine samples on DI, qualified by DSI, and computes their median sequentially with a single comparator.
- Presents the median on DO, qualified by DSO.
- Used as the median stage of the image-filter datapath, downstream of a pixel source that emits 3x3 neighbourhoods serially.

---
 rtl/median.sv | 113 +++++++++++
 tb/tb_median.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/median.sv
// Streaming 9-sample median filter: loads a 9-sample burst, then finds
// the 5th largest value by repeated max-elimination on one comparator.
module median #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  output logic [WIDTH-1:0] DO,
  output logic             DSO
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_smp [9];
  logic [8:0]       r_rm;
  logic [3:0]       r_cnt;
  logic [2:0]       r_pass;
  logic [WIDTH-1:0] r_max;
  logic [3:0]       r_midx;
  logic             r_have;
  logic             r_arm;

  logic [WIDTH-1:0] w_sel;
  logic             w_take;
  logic [WIDTH-1:0] w_max;
  logic [3:0]       w_midx;

  // One candidate per cycle; strict '>' keeps the first of equal maxima
  always_comb begin
    w_sel  = r_smp[r_cnt];
    w_take = !r_rm[r_cnt] && (!r_have || (w_sel > r_max));
    w_max  = w_take ? w_sel : r_max;
    w_midx = w_take ? r_cnt : r_midx;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      for (int k = 0; k < 9; k++) r_smp[k] <= '0;
      r_rm    <= '0;
      r_cnt   <= '0;
      r_pass  <= '0;
      r_max   <= '0;
      r_midx  <= '0;
      r_have  <= 1'b0;
      r_arm   <= 1'b1;
      DO      <= '0;
      DSO     <= 1'b0;
    end else begin
      // A new frame needs DSI low for a cycle after the previous burst
      if (!DSI) r_arm <= 1'b1;
      unique case (r_state)
        IDLE, DONE: begin
          if (DSI && r_arm) begin
            for (int k = 8; k > 0; k--) r_smp[k] <= r_smp[k-1];
            r_smp[0] <= DI;
            DSO      <= 1'b0;
            r_cnt    <= 4'd1;
            r_arm    <= 1'b0;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          if (DSI) begin
            for (int k = 8; k > 0; k--) r_smp[k] <= r_smp[k-1];
            r_smp[0] <= DI;
            if (r_cnt == 4'd8) begin
              r_cnt   <= '0;
              r_pass  <= '0;
              r_rm    <= '0;
              r_have  <= 1'b0;
              r_state <= COMPUTE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        COMPUTE: begin
          r_max  <= w_max;
          r_midx <= w_midx;
          if (r_cnt == 4'd8) begin
            r_cnt  <= '0;
            r_have <= 1'b0;
            if (r_pass == 3'd4) begin
              DO      <= w_max;
              DSO     <= 1'b1;
              r_state <= DONE;
            end else begin
              r_rm[w_midx] <= 1'b1;
              r_pass       <= r_pass + 3'd1;
            end
          end else begin
            r_cnt  <= r_cnt + 4'd1;
            r_have <= r_have || w_take;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median.sv
// Self-checking bench for median: directed frames plus random frames
// checked against a sort-based reference.
module tb_median;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] DI;
  logic       DSI;
  logic [7:0] DO;
  logic       DSO;

  int n_vec = 0;
  int n_err = 0;

  median #(.WIDTH(8)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .DI  (DI),
    .DSI (DSI),
    .DO  (DO),
    .DSO (DSO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_median(input int v[9]);
    int q[$];
    for (int k = 0; k < 9; k++) q.push_back(v[k]);
    q.sort();
    return q[4];
  endfunction

  // Drive nine samples; DSI left high if keep is set
  task automatic send(input int v[9], input bit keep);
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      if (k == 1) chk("dso_drop", DSO, 0);
      DI  = v[k][7:0];
      DSI = 1'b1;
    end
    @(negedge CLK);
    if (!keep) DSI = 1'b0;
    DI = 8'($urandom);
  endtask

  // Called at the negedge right after the 9th capture edge
  task automatic wait_done(input string tag, input int exp);
    int n;
    n = 0;
    while (!DSO && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_lat"}, n, 45);
    chk({tag, "_do"}, DO, exp);
  endtask

  task automatic frame(input string tag, input int v[9]);
    send(v, 1'b0);
    wait_done(tag, ref_median(v));
  endtask

  initial begin
    int v[9];
    int hi;
    nRST = 1'b0;
    DSI  = 1'b1;
    DI   = 8'hA5;
    repeat (2) @(negedge CLK);
    chk("rst_do", DO, 0);
    chk("rst_dso", DSO, 0);
    DSI  = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);

    v = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
    frame("ordered", v);
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      chk("hold_do", DO, 50);
      chk("hold_dso", DSO, 1);
    end

    v = '{255, 255, 255, 255, 0, 0, 0, 0, 7};
    frame("dup7", v);
    chk("dup7_abs", DO, 7);
    v = '{128, 128, 128, 128, 128, 128, 128, 128, 128};
    frame("all128", v);
    chk("all128_abs", DO, 128);
    v = '{0, 0, 0, 0, 0, 255, 255, 255, 255};
    frame("zeros", v);
    chk("zeros_abs", DO, 0);

    // Abort after five samples
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      DI  = 8'(200 + k);
      DSI = 1'b1;
    end
    @(negedge CLK);
    DSI = 1'b0;
    hi  = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (DSO) hi = 1;
    end
    chk("abort_dso", hi, 0);
    v = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    frame("after_abort", v);

    // DSI held high past the frame must not start another
    v = '{3, 1, 4, 1, 5, 9, 2, 6, 5};
    send(v, 1'b1);
    wait_done("long_dsi", ref_median(v));
    repeat (30) @(negedge CLK);
    chk("long_dso", DSO, 1);
    chk("long_do", DO, ref_median(v));
    DSI = 1'b0;
    @(negedge CLK);

    // Reset in the middle of COMPUTE
    v = '{90, 80, 70, 60, 50, 40, 30, 20, 10};
    send(v, 1'b0);
    repeat (20) @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    chk("midrst_dso", DSO, 0);
    chk("midrst_do", DO, 0);
    nRST = 1'b1;
    repeat (45) @(negedge CLK);
    chk("midrst_idle", DSO, 0);
    v = '{17, 250, 3, 99, 100, 101, 0, 42, 77};
    frame("after_rst", v);

    for (int f = 0; f < 1000; f++) begin
      for (int k = 0; k < 9; k++) v[k] = int'($urandom_range(255, 0));
      frame("rand", v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
